regfile_port_arbiter: RTL

//  Shares one 32x32 dual-read/single-write register file between two requesters.

---
 rtl/regfile_port_arbiter.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/regfile_port_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_port_arbiter
//
// Shares one dual-read/single-write register file between two requesters:
// A (datapath sequencer) and B (debug/DMA unit). When both are waiting, the
// requester that was not served last wins. Each operation drives the file pins
// for exactly one cycle (ISSUE). The operation is then acknowledged with a
// one-cycle ACK pulse (COMPLETE). Sustained throughput is one operation every
// three cycles.
//
// Ports
//   clk, rst_n                     clock (rising edge), async active-low reset
//   req_x, we_x                    request (held until ack_x), 1 = write / 0 = read
//   raddr1_x, raddr2_x, waddr_x    read/write register addresses
//   wdata_x                        write data
//   ack_x                          one-cycle completion pulse
//   rdata1_x, rdata2_x             read results; valid with ack_x and held until
//                                  the next read by the same requester
//   rf_read, rf_write              register file strobes (never both 1)
//   rf_addr_r1/r2/w, rf_data_w     register file address/data pins
//   rf_data_r1/r2                  register file read data (only meaningful
//                                  while rf_read is 1)
//   busy                           1 whenever an operation is in flight
// All outputs are registered.
// -----------------------------------------------------------------------------
module regfile_port_arbiter #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 5,
    parameter bit ZERO_REG_RO = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  req_a,
    input  logic                  we_a,
    input  logic [ADDR_WIDTH-1:0] raddr1_a,
    input  logic [ADDR_WIDTH-1:0] raddr2_a,
    input  logic [ADDR_WIDTH-1:0] waddr_a,
    input  logic [DATA_WIDTH-1:0] wdata_a,
    output logic                  ack_a,
    output logic [DATA_WIDTH-1:0] rdata1_a,
    output logic [DATA_WIDTH-1:0] rdata2_a,

    input  logic                  req_b,
    input  logic                  we_b,
    input  logic [ADDR_WIDTH-1:0] raddr1_b,
    input  logic [ADDR_WIDTH-1:0] raddr2_b,
    input  logic [ADDR_WIDTH-1:0] waddr_b,
    input  logic [DATA_WIDTH-1:0] wdata_b,
    output logic                  ack_b,
    output logic [DATA_WIDTH-1:0] rdata1_b,
    output logic [DATA_WIDTH-1:0] rdata2_b,

    output logic                  rf_read,
    output logic                  rf_write,
    output logic [ADDR_WIDTH-1:0] rf_addr_r1,
    output logic [ADDR_WIDTH-1:0] rf_addr_r2,
    output logic [ADDR_WIDTH-1:0] rf_addr_w,
    output logic [DATA_WIDTH-1:0] rf_data_w,
    input  logic [DATA_WIDTH-1:0] rf_data_r1,
    input  logic [DATA_WIDTH-1:0] rf_data_r2,

    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        COMPLETE = 2'd2
    } state_t;

    state_t state, state_d;

    // 1 = B was granted most recently. During ISSUE/COMPLETE this also names
    // the requester that owns the operation in flight.
    logic last_grant_b, last_grant_b_d;

    // Requester selection and its operation fields.
    logic                  sel_b;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_r1, sel_r2, sel_wa;
    logic [DATA_WIDTH-1:0] sel_wd;

    // With both requesting, serve the one not served last; otherwise the lone one.
    assign sel_b  = req_b && (!req_a || !last_grant_b);
    assign sel_we = sel_b ? we_b     : we_a;
    assign sel_r1 = sel_b ? raddr1_b : raddr1_a;
    assign sel_r2 = sel_b ? raddr2_b : raddr2_a;
    assign sel_wa = sel_b ? waddr_b  : waddr_a;
    assign sel_wd = sel_b ? wdata_b  : wdata_a;

    // Next values of the registered outputs.
    logic                  ack_a_d, ack_b_d, busy_d;
    logic                  rf_read_d, rf_write_d;
    logic [ADDR_WIDTH-1:0] rf_addr_r1_d, rf_addr_r2_d, rf_addr_w_d;
    logic [DATA_WIDTH-1:0] rf_data_w_d;
    logic [DATA_WIDTH-1:0] rdata1_a_d, rdata2_a_d, rdata1_b_d, rdata2_b_d;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can
        // leave one unassigned and infer a latch.
        state_d        = state;
        last_grant_b_d = last_grant_b;
        ack_a_d        = 1'b0;
        ack_b_d        = 1'b0;
        rf_read_d      = 1'b0;
        rf_write_d     = 1'b0;
        rf_addr_r1_d   = '0;
        rf_addr_r2_d   = '0;
        rf_addr_w_d    = '0;
        rf_data_w_d    = '0;
        rdata1_a_d     = rdata1_a;
        rdata2_a_d     = rdata2_a;
        rdata1_b_d     = rdata1_b;
        rdata2_b_d     = rdata2_b;

        unique case (state)
            IDLE: begin
                if (req_a || req_b) begin
                    state_d        = ISSUE;
                    last_grant_b_d = sel_b;
                    rf_read_d      = !sel_we;
                    // A write to r0 is still acknowledged but never reaches the file.
                    rf_write_d     = sel_we && !(ZERO_REG_RO && (sel_wa == '0));
                    rf_addr_r1_d   = sel_r1;
                    rf_addr_r2_d   = sel_r2;
                    rf_addr_w_d    = sel_wa;
                    rf_data_w_d    = sel_wd;
                end
            end
            ISSUE: begin
                state_d = COMPLETE;
                // The file only drives its read bus while rf_read is high.
                if (rf_read) begin
                    if (last_grant_b) begin
                        rdata1_b_d = rf_data_r1;
                        rdata2_b_d = rf_data_r2;
                    end else begin
                        rdata1_a_d = rf_data_r1;
                        rdata2_a_d = rf_data_r2;
                    end
                end
                ack_a_d = !last_grant_b;
                ack_b_d = last_grant_b;
            end
            COMPLETE: state_d = IDLE;
            default:  state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            last_grant_b <= 1'b1;
        end else begin
            state        <= state_d;
            last_grant_b <= last_grant_b_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_a      <= 1'b0;
            ack_b      <= 1'b0;
            busy       <= 1'b0;
            rf_read    <= 1'b0;
            rf_write   <= 1'b0;
            rf_addr_r1 <= '0;
            rf_addr_r2 <= '0;
            rf_addr_w  <= '0;
            rf_data_w  <= '0;
            rdata1_a   <= '0;
            rdata2_a   <= '0;
            rdata1_b   <= '0;
            rdata2_b   <= '0;
        end else begin
            ack_a      <= ack_a_d;
            ack_b      <= ack_b_d;
            busy       <= busy_d;
            rf_read    <= rf_read_d;
            rf_write   <= rf_write_d;
            rf_addr_r1 <= rf_addr_r1_d;
            rf_addr_r2 <= rf_addr_r2_d;
            rf_addr_w  <= rf_addr_w_d;
            rf_data_w  <= rf_data_w_d;
            rdata1_a   <= rdata1_a_d;
            rdata2_a   <= rdata2_a_d;
            rdata1_b   <= rdata1_b_d;
            rdata2_b   <= rdata2_b_d;
        end
    end

endmodule
